// File: rtl/xbar_rx_collector.sv
// Pairs header and payload slots from the crossbar receiver into full frames
// and hands them to the output-pipe transactor through a small FWFT FIFO.
module xbar_rx_collector #(
  parameter int unsigned PORTS        = 8,
  parameter int unsigned PACKET_WIDTH = 8,
  parameter int unsigned DEPTH        = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            clear,
  input  logic                            slot_strobe,
  input  logic                            slot_is_header,
  input  logic [PORTS*PACKET_WIDTH-1:0]   rx_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [2*PORTS*PACKET_WIDTH-1:0] out_data,
  output logic [$clog2(DEPTH):0]          fill_level,
  output logic [15:0]                     frame_count,
  output logic                            overflow,
  output logic                            seq_err
);

  localparam int unsigned W  = PACKET_WIDTH;
  localparam int unsigned DW = PORTS * W;
  localparam int unsigned FW = 2 * DW;
  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [0:0] {StWaitHdr, StWaitPld} state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   hdr_q, hdr_d;
  logic [FW-1:0]   mem_q [DEPTH];
  logic [AW:0]     wptr_q, rptr_q;
  logic [15:0]     frame_count_q;
  logic            overflow_q, seq_err_q, seq_err_d;

  logic            frame_valid;
  logic [FW-1:0]   frame;
  logic            full, empty, pop, push_ok;

  // Slot sequencing: a header must precede each payload.
  always_comb begin
    state_d     = state_q;
    hdr_d       = hdr_q;
    seq_err_d   = seq_err_q;
    frame_valid = 1'b0;
    if (slot_strobe) begin
      unique case (state_q)
        StWaitHdr: begin
          if (slot_is_header) begin
            hdr_d   = rx_data;
            state_d = StWaitPld;
          end else begin
            seq_err_d = 1'b1;
          end
        end
        StWaitPld: begin
          if (slot_is_header) begin
            hdr_d     = rx_data;
            seq_err_d = 1'b1;
          end else begin
            frame_valid = 1'b1;
            state_d     = StWaitHdr;
          end
        end
        default: state_d = StWaitHdr;
      endcase
    end
  end

  // Per port: header in the upper word, payload in the lower word.
  always_comb begin
    frame = '0;
    for (int i = 0; i < PORTS; i++) begin
      frame[i*2*W+W +: W] = hdr_q[i*W +: W];
      frame[i*2*W   +: W] = rx_data[i*W +: W];
    end
  end

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
  assign pop     = !empty && out_ready;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign push_ok = frame_valid && (!full || pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StWaitHdr;
      hdr_q         <= '0;
      wptr_q        <= '0;
      rptr_q        <= '0;
      frame_count_q <= '0;
      overflow_q    <= 1'b0;
      seq_err_q     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (clear) begin
      state_q       <= StWaitHdr;
      hdr_q         <= '0;
      wptr_q        <= '0;
      rptr_q        <= '0;
      frame_count_q <= '0;
      overflow_q    <= 1'b0;
      seq_err_q     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      hdr_q     <= hdr_d;
      seq_err_q <= seq_err_d;
      if (pop) rptr_q <= rptr_q + 1'b1;
      if (push_ok) begin
        mem_q[wptr_q[AW-1:0]] <= frame;
        wptr_q                <= wptr_q + 1'b1;
        frame_count_q         <= frame_count_q + 16'd1;
      end
      if (frame_valid && !push_ok) overflow_q <= 1'b1;
    end
  end

  assign out_valid   = !empty;
  assign out_data    = mem_q[rptr_q[AW-1:0]];
  assign fill_level  = wptr_q - rptr_q;
  assign frame_count = frame_count_q;
  assign overflow    = overflow_q;
  assign seq_err     = seq_err_q;

endmodule
